lcd_ctrl_param: RTL and testbench

Parametrised image-buffer controller, successor to the fixed 8x8/8-bit LCD controller.
- Loads a W x H image from IROM into internal storage.
- Executes host commands on a 2x2 operation window anchored at (x,y): move, average, mirror, max, min, rotate.
- Streams the processed image to IRB on a write command.
- Sits between the image ROM and the image result buffer; the host drives cmd/cmd_valid and observes busy/done.

---
 rtl/lcd_ctrl_param_if.sv | 27 ++
 rtl/lcd_ctrl_param.sv | 187 ++++++++++++++++++
 tb/tb_lcd_ctrl_param.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_ctrl_param_if.sv
// Host / IROM / IRB signal bundle for the parametrised LCD image controller.
// The controller connects through the slave modport.
interface lcd_ctrl_param_if #(
    parameter int DW = 8,
    parameter int AW = 6
);
    logic [3:0]    cmd;
    logic          cmd_valid;
    logic [DW-1:0] IROM_Q;
    logic          IROM_EN;
    logic [AW-1:0] IROM_A;
    logic          IRB_RW;
    logic [DW-1:0] IRB_D;
    logic [AW-1:0] IRB_A;
    logic          busy;
    logic          done;

    modport master (
        output cmd, cmd_valid, IROM_Q,
        input  IROM_EN, IROM_A, IRB_RW, IRB_D, IRB_A, busy, done
    );

    modport slave (
        input  cmd, cmd_valid, IROM_Q,
        output IROM_EN, IROM_A, IRB_RW, IRB_D, IRB_A, busy, done
    );
endinterface

// File: rtl/lcd_ctrl_param.sv
// Parametrised LCD image-buffer controller: loads IROM, runs 2x2 window
// commands on the stored image, then streams the result out to IRB.
module lcd_ctrl_param #(
    parameter int DW    = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int AW    = $clog2(IMG_W * IMG_H)
) (
    input logic             clk,
    input logic             reset,
    lcd_ctrl_param_if.slave bus
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int N  = IMG_W * IMG_H;
    localparam int CW = AW + 2;

    localparam logic [2:0] S_LOAD  = 3'd0;
    localparam logic [2:0] S_IDLE  = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [3:0] C_WRITE = 4'd0;
    localparam logic [3:0] C_UP    = 4'd1;
    localparam logic [3:0] C_DOWN  = 4'd2;
    localparam logic [3:0] C_LEFT  = 4'd3;
    localparam logic [3:0] C_RIGHT = 4'd4;
    localparam logic [3:0] C_AVG   = 4'd5;
    localparam logic [3:0] C_MIRX  = 4'd6;
    localparam logic [3:0] C_MIRY  = 4'd7;
    localparam logic [3:0] C_MAX   = 4'd8;
    localparam logic [3:0] C_MIN   = 4'd9;
    localparam logic [3:0] C_CW    = 4'd10;
    localparam logic [3:0] C_CCW   = 4'd11;
    localparam logic [3:0] C_HOME  = 4'd12;

    localparam logic [XW-1:0] X_HOME = XW'(IMG_W / 2 - 1);
    localparam logic [YW-1:0] Y_HOME = YW'(IMG_H / 2 - 1);
    localparam logic [XW-1:0] X_MAX  = XW'(IMG_W - 2);
    localparam logic [YW-1:0] Y_MAX  = YW'(IMG_H - 2);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [3:0]    op;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [DW-1:0] img [N];

    logic [AW-1:0]   a0, a1, a2, a3, ld_a;
    logic [DW-1:0]   p0, p1, p2, p3;
    logic [DW-1:0]   n0, n1, n2, n3;
    logic [DW-1:0]   avg, mx, mn, mx01, mx23, mn01, mn23;
    logic [DW+1:0]   sum;
    logic            win_we, ld_we;

    // Power-of-two width lets the raster address be a plain {y,x} concat
    assign a0 = {y, x};
    assign a1 = {y, x + XW'(1)};
    assign a2 = {y + YW'(1), x};
    assign a3 = {y + YW'(1), x + XW'(1)};

    assign p0 = img[a0];
    assign p1 = img[a1];
    assign p2 = img[a2];
    assign p3 = img[a3];

    assign sum  = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
    assign avg  = sum[DW+1:2];
    assign mx01 = (p0 > p1) ? p0 : p1;
    assign mx23 = (p2 > p3) ? p2 : p3;
    assign mx   = (mx01 > mx23) ? mx01 : mx23;
    assign mn01 = (p0 < p1) ? p0 : p1;
    assign mn23 = (p2 < p3) ? p2 : p3;
    assign mn   = (mn01 < mn23) ? mn01 : mn23;

    // IROM data lags its address by two counts of the load counter
    assign ld_a  = cnt[AW-1:0] - AW'(2);
    assign ld_we = (state == S_LOAD) && (cnt >= CW'(2)) &&
                   (cnt <= CW'(N + 1));

    always_comb begin
        n0 = p0;
        n1 = p1;
        n2 = p2;
        n3 = p3;
        win_we = 1'b0;
        if (state == S_EXEC) begin
            win_we = 1'b1;
            unique case (op)
                C_AVG:  begin n0 = avg; n1 = avg; n2 = avg; n3 = avg; end
                C_MIRX: begin n0 = p2; n1 = p3; n2 = p0; n3 = p1; end
                C_MIRY: begin n0 = p1; n1 = p0; n2 = p3; n3 = p2; end
                C_MAX:  begin n0 = mx; n1 = mx; n2 = mx; n3 = mx; end
                C_MIN:  begin n0 = mn; n1 = mn; n2 = mn; n3 = mn; end
                C_CW:   begin n0 = p2; n1 = p0; n2 = p3; n3 = p1; end
                C_CCW:  begin n0 = p1; n1 = p3; n2 = p0; n3 = p2; end
                default: win_we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (ld_we) img[ld_a] <= bus.IROM_Q;
            if (win_we) begin
                img[a0] <= n0;
                img[a1] <= n1;
                img[a2] <= n2;
                img[a3] <= n3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_LOAD;
            cnt         <= '0;
            op          <= '0;
            x           <= X_HOME;
            y           <= Y_HOME;
            bus.IROM_EN <= 1'b1;
            bus.IROM_A  <= '0;
            bus.IRB_RW  <= 1'b1;
            bus.IRB_D   <= '0;
            bus.IRB_A   <= '0;
            bus.busy    <= 1'b1;
            bus.done    <= 1'b0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    cnt <= cnt + CW'(1);
                    if (cnt < CW'(N)) begin
                        bus.IROM_EN <= 1'b0;
                        bus.IROM_A  <= cnt[AW-1:0];
                    end else begin
                        bus.IROM_EN <= 1'b1;
                    end
                    if (cnt == CW'(N + 2)) begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.busy <= 1'b1;
                        if (bus.cmd == C_WRITE) begin
                            state      <= S_WRITE;
                            bus.IRB_RW <= 1'b0;
                            bus.IRB_A  <= '0;
                            bus.IRB_D  <= img[0];
                            cnt        <= CW'(1);
                        end else begin
                            state <= S_EXEC;
                            op    <= bus.cmd;
                        end
                    end
                end
                S_EXEC: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                    unique case (op)
                        C_UP:    if (y != '0) y <= y - YW'(1);
                        C_DOWN:  if (y != Y_MAX) y <= y + YW'(1);
                        C_LEFT:  if (x != '0) x <= x - XW'(1);
                        C_RIGHT: if (x != X_MAX) x <= x + XW'(1);
                        C_HOME:  begin x <= X_HOME; y <= Y_HOME; end
                        default: ;
                    endcase
                end
                S_WRITE: begin
                    if (cnt == CW'(N)) begin
                        bus.IRB_RW <= 1'b1;
                        bus.done   <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        bus.IRB_A <= cnt[AW-1:0];
                        bus.IRB_D <= img[cnt[AW-1:0]];
                        cnt       <= cnt + CW'(1);
                    end
                end
                S_DONE: ;
                default: state <= S_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Directed bench for lcd_ctrl_param: 8x8/8-bit vectors plus a 16x4/10-bit
// instance for the wide-pixel averaging and latency corner.
module tb_lcd_ctrl_param;
    logic clk = 1'b0;
    logic rst1 = 1'b0;
    logic rst2 = 1'b0;
    always #5 clk = ~clk;

    lcd_ctrl_param_if #(.DW(8),  .AW(6)) b1 ();
    lcd_ctrl_param_if #(.DW(10), .AW(6)) b2 ();

    lcd_ctrl_param #(.DW(8), .IMG_W(8), .IMG_H(8)) u1 (
        .clk(clk), .reset(rst1), .bus(b1.slave)
    );
    lcd_ctrl_param #(.DW(10), .IMG_W(16), .IMG_H(4)) u2 (
        .clk(clk), .reset(rst2), .bus(b2.slave)
    );

    logic [7:0] rom1 [64];
    logic [9:0] rom2 [64];
    logic [7:0] expimg [64];
    logic [9:0] exp2 [64];

    always @(posedge clk) if (!b1.IROM_EN) b1.IROM_Q <= rom1[b1.IROM_A];
    always @(posedge clk) if (!b2.IROM_EN) b2.IROM_Q <= rom2[b2.IROM_A];

    int n_chk = 0;
    int n_fail = 0;
    int cur = -1;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL [%0d] %s: got %0d, expected %0d", cur, nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [4:0]      ncmd;
        logic [63:0]     cmds;
        logic [2:0]      nrom;
        logic [3:0][7:0] rom_a;
        logic [3:0][7:0] rom_v;
        logic [2:0]      nexp;
        logic [3:0][7:0] exp_a;
        logic [3:0][7:0] exp_v;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic chk_rst1();
        check("rst_irom_en", int'(b1.IROM_EN), 1);
        check("rst_irom_a", int'(b1.IROM_A), 0);
        check("rst_irb_rw", int'(b1.IRB_RW), 1);
        check("rst_irb_d", int'(b1.IRB_D), 0);
        check("rst_irb_a", int'(b1.IRB_A), 0);
        check("rst_busy", int'(b1.busy), 1);
        check("rst_done", int'(b1.done), 0);
    endtask

    task automatic wait_load1(output int cyc);
        @(negedge clk);
        check("load_en", int'(b1.IROM_EN), 0);
        check("load_a0", int'(b1.IROM_A), 0);
        cyc = 0;
        while (b1.busy === 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic reset_load1();
        int cyc;
        @(negedge clk);
        rst1 = 1'b0;
        @(negedge clk);
        chk_rst1();
        rst1 = 1'b1;
        wait_load1(cyc);
        check("load_latency", cyc, 66);
    endtask

    task automatic send1(input logic [3:0] c);
        int t = 0;
        while (b1.busy !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("idle_timeout", int'(b1.busy), 0);
        b1.cmd = c;
        b1.cmd_valid = 1'b1;
        @(negedge clk);
        b1.cmd_valid = 1'b0;
        check("accept_busy", int'(b1.busy), 1);
        if (c != 4'd0) begin
            @(negedge clk);
            check("exec_1cyc", int'(b1.busy), 0);
        end
    endtask

    task automatic dump1();
        for (int k = 0; k < 64; k++) begin
            check("irb_rw", int'(b1.IRB_RW), 0);
            check("irb_a", int'(b1.IRB_A), k);
            check("irb_d", int'(b1.IRB_D), int'(expimg[k]));
            if (k == 63) check("done_early", int'(b1.done), 0);
            @(negedge clk);
        end
        check("irb_rw_end", int'(b1.IRB_RW), 1);
        check("done_set", int'(b1.done), 1);
        check("busy_done", int'(b1.busy), 1);
    endtask

    task automatic default_image();
        for (int i = 0; i < 64; i++) begin
            rom1[i] = 8'(i);
            expimg[i] = 8'(i);
        end
    endtask

    initial begin
        b1.cmd = '0;
        b1.cmd_valid = 1'b0;
        b2.cmd = '0;
        b2.cmd_valid = 1'b0;

        vecs[0]  = '{ncmd: 5'd0, cmds: 64'h0, nrom: 3'd0, rom_a: '0,
                     rom_v: '0, nexp: 3'd0, exp_a: '0, exp_v: '0};
        vecs[1]  = '{ncmd: 5'd11, cmds: 64'h5_33333_11111, nrom: 3'd0,
                     rom_a: '0, rom_v: '0, nexp: 3'd4,
                     exp_a: {8'd9, 8'd8, 8'd1, 8'd0}, exp_v: {4{8'd4}}};
        vecs[2]  = '{ncmd: 5'd13, cmds: 64'h6_222_444_222_444, nrom: 3'd0,
                     rom_a: '0, rom_v: '0, nexp: 3'd4,
                     exp_a: {8'd63, 8'd62, 8'd55, 8'd54},
                     exp_v: {8'd55, 8'd54, 8'd63, 8'd62}};
        vecs[3]  = '{ncmd: 5'd3, cmds: 64'hEBA, nrom: 3'd0, rom_a: '0,
                     rom_v: '0, nexp: 3'd0, exp_a: '0, exp_v: '0};
        vecs[4]  = '{ncmd: 5'd2, cmds: 64'h98, nrom: 3'd4,
                     rom_a: {8'd36, 8'd35, 8'd28, 8'd27},
                     rom_v: {8'd7, 8'd3, 8'd200, 8'd10}, nexp: 3'd4,
                     exp_a: {8'd36, 8'd35, 8'd28, 8'd27},
                     exp_v: {4{8'd200}}};
        vecs[5]  = '{ncmd: 5'd1, cmds: 64'hA, nrom: 3'd0, rom_a: '0,
                     rom_v: '0, nexp: 3'd4,
                     exp_a: {8'd36, 8'd35, 8'd28, 8'd27},
                     exp_v: {8'd28, 8'd36, 8'd27, 8'd35}};
        vecs[6]  = '{ncmd: 5'd1, cmds: 64'hB, nrom: 3'd0, rom_a: '0,
                     rom_v: '0, nexp: 3'd4,
                     exp_a: {8'd36, 8'd35, 8'd28, 8'd27},
                     exp_v: {8'd35, 8'd27, 8'd36, 8'd28}};
        vecs[7]  = '{ncmd: 5'd1, cmds: 64'h7, nrom: 3'd0, rom_a: '0,
                     rom_v: '0, nexp: 3'd4,
                     exp_a: {8'd36, 8'd35, 8'd28, 8'd27},
                     exp_v: {8'd35, 8'd36, 8'd27, 8'd28}};
        vecs[8]  = '{ncmd: 5'd4, cmds: 64'h9C13, nrom: 3'd0, rom_a: '0,
                     rom_v: '0, nexp: 3'd4,
                     exp_a: {8'd36, 8'd35, 8'd28, 8'd27},
                     exp_v: {4{8'd27}}};
        vecs[9]  = '{ncmd: 5'd3, cmds: 64'h542, nrom: 3'd0, rom_a: '0,
                     rom_v: '0, nexp: 3'd4,
                     exp_a: {8'd45, 8'd44, 8'd37, 8'd36},
                     exp_v: {4{8'd40}}};
        vecs[10] = '{ncmd: 5'd1, cmds: 64'h8, nrom: 3'd0, rom_a: '0,
                     rom_v: '0, nexp: 3'd4,
                     exp_a: {8'd36, 8'd35, 8'd28, 8'd27},
                     exp_v: {4{8'd36}}};

        for (int v = 0; v < NV; v++) begin
            logic [63:0] cs;
            cur = v;
            default_image();
            for (int j = 0; j < int'(vecs[v].nrom); j++) begin
                rom1[vecs[v].rom_a[j][5:0]] = vecs[v].rom_v[j];
                expimg[vecs[v].rom_a[j][5:0]] = vecs[v].rom_v[j];
            end
            for (int j = 0; j < int'(vecs[v].nexp); j++)
                expimg[vecs[v].exp_a[j][5:0]] = vecs[v].exp_v[j];
            reset_load1();
            cs = vecs[v].cmds;
            for (int k = 0; k < int'(vecs[v].ncmd); k++)
                send1(cs[4*k +: 4]);
            send1(4'd0);
            dump1();
        end

        // Command held through the whole load must be ignored
        begin
            int cyc;
            cur = 100;
            default_image();
            @(negedge clk);
            rst1 = 1'b0;
            @(negedge clk);
            rst1 = 1'b1;
            b1.cmd = 4'd7;
            b1.cmd_valid = 1'b1;
            wait_load1(cyc);
            b1.cmd_valid = 1'b0;
            check("load_latency_hold", cyc, 66);
            @(negedge clk);
            check("idle_after_hold", int'(b1.busy), 0);
            send1(4'd0);
            dump1();
        end

        // Strobe held across the edge where busy falls is not accepted
        begin
            cur = 101;
            default_image();
            expimg[27] = 8'd28;
            expimg[28] = 8'd27;
            expimg[35] = 8'd36;
            expimg[36] = 8'd35;
            reset_load1();
            b1.cmd = 4'd7;
            b1.cmd_valid = 1'b1;
            @(negedge clk);
            check("hold_accept", int'(b1.busy), 1);
            @(negedge clk);
            check("hold_exec_end", int'(b1.busy), 0);
            b1.cmd_valid = 1'b0;
            @(negedge clk);
            check("hold_no_second", int'(b1.busy), 0);
            send1(4'd0);
            dump1();
            // DONE ignores further commands
            b1.cmd = 4'd0;
            b1.cmd_valid = 1'b1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check("done_rw", int'(b1.IRB_RW), 1);
                check("done_sticky", int'(b1.done), 1);
                check("done_busy", int'(b1.busy), 1);
            end
            b1.cmd_valid = 1'b0;
        end

        // Reset in the middle of the write stream
        begin
            int t = 0;
            int cyc;
            cur = 102;
            default_image();
            reset_load1();
            send1(4'd0);
            while (b1.IRB_A != 6'd20 && t < 100) begin
                @(negedge clk);
                t++;
            end
            check("reach_a20", int'(b1.IRB_A), 20);
            rst1 = 1'b0;
            @(negedge clk);
            chk_rst1();
            rst1 = 1'b1;
            wait_load1(cyc);
            check("reload_latency", cyc, 66);
            check("reload_done", int'(b1.done), 0);
            send1(4'd0);
            dump1();
        end

        // 16x4, 10-bit instance: AVG without overflow
        begin
            int cyc = 0;
            cur = 200;
            rst1 = 1'b0;
            for (int i = 0; i < 64; i++) begin
                rom2[i] = 10'(i);
                exp2[i] = 10'(i);
            end
            rom2[23] = 10'd1023;
            rom2[24] = 10'd1023;
            rom2[39] = 10'd1023;
            rom2[40] = 10'd1022;
            exp2[23] = 10'd1022;
            exp2[24] = 10'd1022;
            exp2[39] = 10'd1022;
            exp2[40] = 10'd1022;
            @(negedge clk);
            check("w_rst_busy", int'(b2.busy), 1);
            check("w_rst_en", int'(b2.IROM_EN), 1);
            rst2 = 1'b1;
            @(negedge clk);
            check("w_load_en", int'(b2.IROM_EN), 0);
            while (b2.busy === 1'b1 && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            check("w_load_latency", cyc, 66);
            b2.cmd = 4'd5;
            b2.cmd_valid = 1'b1;
            @(negedge clk);
            b2.cmd_valid = 1'b0;
            check("w_exec_busy", int'(b2.busy), 1);
            @(negedge clk);
            check("w_exec_end", int'(b2.busy), 0);
            b2.cmd = 4'd0;
            b2.cmd_valid = 1'b1;
            @(negedge clk);
            b2.cmd_valid = 1'b0;
            for (int k = 0; k < 64; k++) begin
                check("w_irb_rw", int'(b2.IRB_RW), 0);
                check("w_irb_a", int'(b2.IRB_A), k);
                check("w_irb_d", int'(b2.IRB_D), int'(exp2[k]));
                @(negedge clk);
            end
            check("w_done", int'(b2.done), 1);
            check("w_rw_end", int'(b2.IRB_RW), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
